// File: rtl/fft_frame_packer_pkg.sv
// Shared sizes and field positions for the FFT frame packer.
// Sample word carries re in the upper half and im in the lower half.
package fft_frame_packer_pkg;

  localparam int N_BINS   = 16;
  localparam int BIN_W    = 4;
  localparam int SAMPLE_W = 32;
  localparam int MAG_W    = 32;
  localparam int COMP_W   = 16;

  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  typedef struct packed {
    logic [BIN_W-1:0] slot;
    logic             err;
  } slot_tag_t;

endpackage

// File: rtl/fft_frame_packer_bin_magnitude.sv
// Registered magnitude of one complex bin: power (MAG_MODE=1) or L1 (MAG_MODE=0).
// The output register only loads when i_en is high, so it holds through input bubbles.
module bin_magnitude
  import fft_frame_packer_pkg::*;
#(
  parameter int MAG_MODE = 1
) (
  input  logic                clk,
  input  logic                i_en,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic [MAG_W-1:0]    o_mag
);

  logic signed [COMP_W-1:0] w_re;
  logic signed [COMP_W-1:0] w_im;
  logic        [MAG_W-1:0]  w_mag;

  assign w_re = i_sample[RE_MSB:RE_LSB];
  assign w_im = i_sample[IM_MSB:IM_LSB];

  generate
    if (MAG_MODE == 1) begin : g_power
      logic signed [MAG_W-1:0] w_re_x;
      logic signed [MAG_W-1:0] w_im_x;
      logic signed [MAG_W-1:0] w_re_sq;
      logic signed [MAG_W-1:0] w_im_sq;

      assign w_re_x  = {{(MAG_W-COMP_W){w_re[COMP_W-1]}}, w_re};
      assign w_im_x  = {{(MAG_W-COMP_W){w_im[COMP_W-1]}}, w_im};
      assign w_re_sq = w_re_x * w_re_x;
      assign w_im_sq = w_im_x * w_im_x;
      // Each square is at most 2^30, so the unsigned sum never exceeds 2^31.
      assign w_mag   = $unsigned(w_re_sq) + $unsigned(w_im_sq);
    end else begin : g_l1
      logic [COMP_W:0] w_abs_re;
      logic [COMP_W:0] w_abs_im;

      // One extra bit so that |-32768| = 32768 is representable.
      assign w_abs_re = w_re[COMP_W-1] ? ((COMP_W+1)'(0) - {w_re[COMP_W-1], w_re})
                                       : {1'b0, w_re};
      assign w_abs_im = w_im[COMP_W-1] ? ((COMP_W+1)'(0) - {w_im[COMP_W-1], w_im})
                                       : {1'b0, w_im};
      assign w_mag    = {{(MAG_W-COMP_W-1){1'b0}}, w_abs_re}
                      + {{(MAG_W-COMP_W-1){1'b0}}, w_abs_im};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_en) begin
      o_mag <= w_mag;
    end
  end

endmodule

// File: rtl/fft_frame_packer.sv
// Packs 16 complex FFT bins into a frame of magnitudes; 3-cycle pipeline, one
// fft_valid pulse per completed frame, partial frames cut by in_sop flagged on frame_err.
module fft_frame_packer
  import fft_frame_packer_pkg::*;
#(
  parameter int MAG_MODE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sop,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                fft_valid,
  output logic [MAG_W-1:0]    fft_d0,
  output logic [MAG_W-1:0]    fft_d1,
  output logic [MAG_W-1:0]    fft_d2,
  output logic [MAG_W-1:0]    fft_d3,
  output logic [MAG_W-1:0]    fft_d4,
  output logic [MAG_W-1:0]    fft_d5,
  output logic [MAG_W-1:0]    fft_d6,
  output logic [MAG_W-1:0]    fft_d7,
  output logic [MAG_W-1:0]    fft_d8,
  output logic [MAG_W-1:0]    fft_d9,
  output logic [MAG_W-1:0]    fft_d10,
  output logic [MAG_W-1:0]    fft_d11,
  output logic [MAG_W-1:0]    fft_d12,
  output logic [MAG_W-1:0]    fft_d13,
  output logic [MAG_W-1:0]    fft_d14,
  output logic [MAG_W-1:0]    fft_d15,
  output logic                frame_err
);

  logic [BIN_W-1:0]    r_slot;
  logic [BIN_W-1:0]    w_slot;
  logic                w_sop_err;

  logic                r_s1_vld;
  slot_tag_t           r_s1_tag;
  logic [SAMPLE_W-1:0] r_s1_sample;

  logic                r_s2_vld;
  slot_tag_t           r_s2_tag;
  logic [MAG_W-1:0]    w_mag;
  logic                w_last;

  logic [MAG_W-1:0]    r_work [N_BINS];
  logic [MAG_W-1:0]    r_bank [N_BINS];

  // A qualified sop restarts the frame at slot 0; a nonzero count means the
  // frame in progress is abandoned.
  assign w_slot    = in_sop ? '0 : r_slot;
  assign w_sop_err = in_sop && (r_slot != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot <= '0;
    end else if (in_valid) begin
      r_slot <= w_slot + BIN_W'(1);
    end
  end

  // S1: capture sample and its slot; data holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_s1_tag    <= '{slot: w_slot, err: w_sop_err};
      r_s1_sample <= in_data;
    end
  end

  // S2: magnitude register lives inside bin_magnitude.
  bin_magnitude #(
    .MAG_MODE (MAG_MODE)
  ) u_bin_magnitude (
    .clk      (clk),
    .i_en     (r_s1_vld),
    .i_sample (r_s1_sample),
    .o_mag    (w_mag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (r_s1_vld) begin
      r_s2_tag <= r_s1_tag;
    end
  end

  // S3: write working buffer; slot 15 publishes the whole frame.
  assign w_last = r_s2_vld && (r_s2_tag.slot == BIN_W'(N_BINS-1));

  always_ff @(posedge clk) begin
    if (r_s2_vld) begin
      r_work[r_s2_tag.slot] <= w_mag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BINS; i++) begin
        r_bank[i] <= '0;
      end
      fft_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w_last) begin
        for (int i = 0; i < N_BINS; i++) begin
          r_bank[i] <= (i == N_BINS-1) ? w_mag : r_work[i];
        end
      end
      fft_valid <= w_last;
      frame_err <= r_s2_vld && r_s2_tag.err;
    end
  end

  assign fft_d0  = r_bank[0];
  assign fft_d1  = r_bank[1];
  assign fft_d2  = r_bank[2];
  assign fft_d3  = r_bank[3];
  assign fft_d4  = r_bank[4];
  assign fft_d5  = r_bank[5];
  assign fft_d6  = r_bank[6];
  assign fft_d7  = r_bank[7];
  assign fft_d8  = r_bank[8];
  assign fft_d9  = r_bank[9];
  assign fft_d10 = r_bank[10];
  assign fft_d11 = r_bank[11];
  assign fft_d12 = r_bank[12];
  assign fft_d13 = r_bank[13];
  assign fft_d14 = r_bank[14];
  assign fft_d15 = r_bank[15];

endmodule
